// File: rtl/man_tx_pkg.sv
// Shared types and constants for the Type-A frame serializer.
//   tx_state_e      : serializer FSM states
//   CRC_A_PRESET    : CRC_A start value, reloaded at every SOF
//   CRC_A_POLY_REFL : reflected CRC_A polynomial (x^16+x^12+x^5+1)
//   SOF_BIT         : level driven during the start-of-frame ETU
package man_tx_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOF,
    ST_DATA,
    ST_PARITY,
    ST_GUARD
  } tx_state_e;

  localparam logic [15:0] CRC_A_PRESET    = 16'h6363;
  localparam logic [15:0] CRC_A_POLY_REFL = 16'h8408;
  localparam logic        SOF_BIT         = 1'b1;
endpackage

// File: rtl/man_frame_tx_if.sv
// Byte handshake into the serializer plus its modulator-side outputs.
//   in_valid/in_byte/in_last : frame byte offer from upstream
//   out_ready                : byte taken when in_valid & out_ready at posedge
//   out_data/out_enable      : bit stream and enable for the Manchester modulator
//   out_busy                 : frame start through end of guard
//   out_error                : one-cycle underrun abort pulse
// master = upstream byte source, slave = serializer.
interface man_frame_tx_if;
  logic       in_valid;
  logic [7:0] in_byte;
  logic       in_last;
  logic       out_ready;
  logic       out_data;
  logic       out_enable;
  logic       out_busy;
  logic       out_error;

  modport master (
    output in_valid, in_byte, in_last,
    input  out_ready, out_data, out_enable, out_busy, out_error
  );

  modport slave (
    input  in_valid, in_byte, in_last,
    output out_ready, out_data, out_enable, out_busy, out_error
  );
endinterface

// File: rtl/crc_a_serial.sv
// Bit-serial CRC_A (ISO 14443-A), LSB-first, reflected polynomial.
//   clk, rst_n : clock, async active-low reset
//   clr        : reload preset (frame start)
//   en         : fold bit_in into the CRC this cycle
//   bit_in     : transmitted data bit
//   crc_out    : current CRC register; low byte is sent first
module crc_a_serial
  import man_tx_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic        bit_in,
  output logic [15:0] crc_out
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   crc_out <= CRC_A_PRESET;
    else if (clr) crc_out <= CRC_A_PRESET;
    else if (en)  crc_out <= (crc_out >> 1) ^ ((crc_out[0] ^ bit_in) ? CRC_A_POLY_REFL : 16'h0000);
  end
endmodule

// File: rtl/man_frame_tx.sv
// ISO 14443-A PICC->PCD frame serializer feeding the Manchester modulator.
// Emits SOF, then each byte LSB-first with odd parity, one bit per ETU, then
// holds enable low for GUARD_ETUS ETUs. A missing byte at a parity boundary
// (frame not yet ended) aborts the frame with a one-cycle out_error pulse.
// Ports:
//   clk   : subcarrier clock (fc/16), posedge
//   rst_n : async active-low reset
//   bus   : man_frame_tx_if.slave (byte handshake in, modulator signals out)
// Parameters: ETU_CLKS (clk per ETU, >= 2), GUARD_ETUS (post-frame quiet ETUs).
// Build option: define MAN_TX_CRC_EN to append CRC_A (low byte, then high
// byte, each with parity) after the in_last byte.
module man_frame_tx
  import man_tx_pkg::*;
#(
  parameter int ETU_CLKS   = 8,
  parameter int GUARD_ETUS = 2
) (
  input  logic clk,
  input  logic rst_n,
  man_frame_tx_if.slave bus
);
  localparam int CW = $clog2(ETU_CLKS);
  localparam int BW = (GUARD_ETUS > 8) ? $clog2(GUARD_ETUS) : 3;

  tx_state_e      state, state_n;
  logic [CW-1:0]  etu_cnt;
  logic [BW-1:0]  bit_cnt, bit_cnt_n;
  logic           hold_full, hold_last;
  logic [7:0]     hold_byte;
  logic [7:0]     shift, shift_n;
  logic           par, par_n;
  logic           cur_last, cur_last_n;
  logic           err, err_n;
  logic           rdy;
  logic           load;
  logic           etu_end, accept;

  assign etu_end = (etu_cnt == CW'(ETU_CLKS - 1));
  assign accept  = bus.in_valid & bus.out_ready;

`ifdef MAN_TX_CRC_EN
  // 0: user bytes, 1: sending CRC low byte, 2: sending CRC high byte
  logic [1:0]  crc_ph, crc_ph_n;
  logic [15:0] crc;

  crc_a_serial u_crc (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state == ST_SOF),
    .en      ((state == ST_DATA) && etu_end && (crc_ph == 2'd0)),
    .bit_in  (shift[0]),
    .crc_out (crc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) crc_ph <= 2'd0;
    else        crc_ph <= crc_ph_n;
  end
`endif

  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    shift_n    = shift;
    par_n      = par;
    cur_last_n = cur_last;
    err_n      = 1'b0;
    load       = 1'b0;
`ifdef MAN_TX_CRC_EN
    crc_ph_n   = crc_ph;
`endif
    case (state)
      ST_IDLE: if (hold_full) state_n = ST_SOF;
      ST_SOF: if (etu_end) begin
        // SOF is only entered with the holding register full
        load       = 1'b1;
        shift_n    = hold_byte;
        cur_last_n = hold_last;
        par_n      = 1'b1;
        bit_cnt_n  = '0;
        state_n    = ST_DATA;
`ifdef MAN_TX_CRC_EN
        crc_ph_n   = 2'd0;
`endif
      end
      ST_DATA: if (etu_end) begin
        shift_n = shift >> 1;
        par_n   = par ^ shift[0];
        if (bit_cnt == BW'(7)) begin
          bit_cnt_n = '0;
          state_n   = ST_PARITY;
        end else begin
          bit_cnt_n = bit_cnt + BW'(1);
        end
      end
      ST_PARITY: if (etu_end) begin
        par_n     = 1'b1;
        bit_cnt_n = '0;
`ifdef MAN_TX_CRC_EN
        if (crc_ph == 2'd1) begin
          shift_n  = crc[15:8];
          crc_ph_n = 2'd2;
          state_n  = ST_DATA;
        end else if (crc_ph == 2'd2) begin
          state_n  = ST_GUARD;
        end else if (cur_last) begin
          shift_n  = crc[7:0];
          crc_ph_n = 2'd1;
          state_n  = ST_DATA;
        end else
`else
        if (cur_last) begin
          state_n = ST_GUARD;
        end else
`endif
        if (hold_full) begin
          load       = 1'b1;
          shift_n    = hold_byte;
          cur_last_n = hold_last;
          state_n    = ST_DATA;
        end else begin
          // underrun: queued bytes stay put for the next frame
          err_n   = 1'b1;
          state_n = ST_GUARD;
        end
      end
      ST_GUARD: if (etu_end) begin
        if (bit_cnt == BW'(GUARD_ETUS - 1)) begin
          bit_cnt_n = '0;
          // a byte that arrived during guard starts its SOF right away
          state_n   = hold_full ? ST_SOF : ST_IDLE;
        end else begin
          bit_cnt_n = bit_cnt + BW'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      etu_cnt  <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      par      <= 1'b0;
      cur_last <= 1'b0;
      err      <= 1'b0;
      rdy      <= 1'b0;
    end else begin
      state    <= state_n;
      etu_cnt  <= ((state == ST_IDLE) || etu_end) ? '0 : etu_cnt + CW'(1);
      bit_cnt  <= bit_cnt_n;
      shift    <= shift_n;
      par      <= par_n;
      cur_last <= cur_last_n;
      err      <= err_n;
      rdy      <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_full <= 1'b0;
      hold_byte <= '0;
      hold_last <= 1'b0;
    end else if (accept) begin
      hold_full <= 1'b1;
      hold_byte <= bus.in_byte;
      hold_last <= bus.in_last;
    end else if (load) begin
      hold_full <= 1'b0;
    end
  end

  // outputs decode from registered state only, so they move on bit boundaries
  always_comb begin
    bus.out_enable = 1'b0;
    bus.out_data   = 1'b0;
    case (state)
      ST_SOF:    begin bus.out_enable = 1'b1; bus.out_data = SOF_BIT;  end
      ST_DATA:   begin bus.out_enable = 1'b1; bus.out_data = shift[0]; end
      ST_PARITY: begin bus.out_enable = 1'b1; bus.out_data = par;      end
      default:   ;
    endcase
  end

  assign bus.out_ready = rdy & ~hold_full;
  assign bus.out_busy  = (state != ST_IDLE);
  assign bus.out_error = err;
endmodule

// File: tb/tb_man_frame_tx.sv
// Self-checking bench for man_frame_tx. Frames are described as byte lists;
// a reference model expands them to the expected per-ETU bit sequence
// (SOF, LSB-first data, odd parity, optional CRC_A computed bytewise) and the
// recorded output trace is compared against it.
module tb_man_frame_tx;
  localparam int ETU   = 8;
  localparam int GUARD = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  man_frame_tx_if bus();

  man_frame_tx #(.ETU_CLKS(ETU), .GUARD_ETUS(GUARD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic en;
    logic d;
    logic err;
    logic busy;
  } smp_t;

  smp_t        tr[$];
  bit          rec = 1'b0;
  int          vecs = 0;
  int          errs = 0;
  bit          exp_bits[$];
  int          exp_len[$];
  logic [7:0]  fb[$];

  always @(negedge clk)
    if (rec) tr.push_back(smp_t'{bus.out_enable, bus.out_data, bus.out_error, bus.out_busy});

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

`ifdef MAN_TX_CRC_EN
  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
    logic [7:0] ch;
    ch = b ^ c[7:0];
    ch = ch ^ {ch[3:0], 4'b0000};
    return {8'h00, c[15:8]} ^ {ch, 8'h00} ^ {5'b00000, ch, 3'b000} ^ {12'h000, ch[7:4]};
  endfunction
`endif

  function automatic void push_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
    exp_bits.push_back(~^b);
  endfunction

  // expand fb[] into one expected frame; with_crc=0 for aborted frames
  function automatic void add_frame(input bit with_crc);
    int n0;
`ifdef MAN_TX_CRC_EN
    logic [15:0] crc;
    crc = 16'h6363;
    foreach (fb[k]) crc = crc_upd(crc, fb[k]);
`endif
    n0 = exp_bits.size();
    exp_bits.push_back(1'b1);
    foreach (fb[k]) push_byte(fb[k]);
`ifdef MAN_TX_CRC_EN
    if (with_crc) begin
      push_byte(crc[7:0]);
      push_byte(crc[15:8]);
    end
`else
    if (with_crc) n0 = n0 + 0;
`endif
    exp_len.push_back(exp_bits.size() - n0);
    fb.delete();
  endfunction

  // call at a negedge; returns at the negedge after the accepting posedge
  task automatic send_byte(input logic [7:0] b, input logic l, output int waited);
    waited = 0;
    bus.in_byte  = b;
    bus.in_last  = l;
    bus.in_valid = 1'b1;
    while (!bus.out_ready && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    vecs++;
    if (bus.out_ready !== 1'b1) begin
      errs++;
      $display("FAIL send_timeout byte %h: ready %b, want 1", b, bus.out_ready);
      waited = -1;
    end else begin
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int quiet = 0;
    for (int n = 0; n < 3000 && quiet < 4; n++) begin
      @(negedge clk);
      if (!bus.out_busy && bus.out_ready) quiet++;
      else quiet = 0;
    end
    vecs++;
    if (quiet < 4) begin
      errs++;
      $display("FAIL drain_timeout: busy %b ready %b, want 0/1", bus.out_busy, bus.out_ready);
    end
  endtask

  // compare recorded trace against exp_bits/exp_len; gap_exp<0 skips gap check
  task automatic check_trace(input string name, input int gap_exp, input int err_exp);
    int p = 0, bi = 0, prev_end = -1, start, q, glen, ecnt;
    foreach (exp_len[f]) begin
      while (p < tr.size() && !tr[p].en) p++;
      start = p;
      while (p < tr.size() && tr[p].en) p++;
      vecs++;
      if ((p - start) !== exp_len[f] * ETU) begin
        errs++;
        $display("FAIL %s enable_len frame %0d: got %0d cycles, want %0d", name, f, p - start, exp_len[f] * ETU);
      end
      if (gap_exp >= 0 && prev_end >= 0) begin
        vecs++;
        if ((start - prev_end) !== gap_exp) begin
          errs++;
          $display("FAIL %s gap before frame %0d: got %0d cycles, want %0d", name, f, start - prev_end, gap_exp);
        end
      end
      for (int b = 0; b < exp_len[f]; b++) begin
        logic got = exp_bits[bi + b];
        for (int k = 0; k < ETU; k++) begin
          int idx = start + b * ETU + k;
          if (idx >= p) got = 1'bx;
          else if (tr[idx].d !== exp_bits[bi + b]) got = tr[idx].d;
        end
        vecs++;
        if (got !== exp_bits[bi + b]) begin
          errs++;
          $display("FAIL %s bit frame %0d idx %0d: got %b, want %b", name, f, b, got, exp_bits[bi + b]);
        end
      end
      bi += exp_len[f];
      prev_end = p;
    end
    q = p;
    while (q < tr.size() && tr[q].busy && !tr[q].en) q++;
    glen = q - p;
    vecs++;
    if (glen !== GUARD * ETU || q >= tr.size() || tr[q].busy !== 1'b0) begin
      errs++;
      $display("FAIL %s guard: got %0d busy cycles after EOF, want %0d then busy low", name, glen, GUARD * ETU);
    end
    ecnt = 0;
    foreach (tr[i]) if (tr[i].err) ecnt++;
    vecs++;
    if (ecnt !== err_exp) begin
      errs++;
      $display("FAIL %s error_pulses: got %0d cycles, want %0d", name, ecnt, err_exp);
    end
    if (err_exp > 0 && prev_end >= 0 && prev_end < tr.size()) begin
      vecs++;
      if (tr[prev_end].err !== 1'b1) begin
        errs++;
        $display("FAIL %s error_timing: got %b at enable fall, want 1", name, tr[prev_end].err);
      end
    end
    tr.delete();
    exp_bits.delete();
    exp_len.delete();
  endtask

  task automatic test_reset();
    #2;
    vecs++;
    if ({bus.out_ready, bus.out_enable, bus.out_data, bus.out_busy, bus.out_error} !== 5'b0) begin
      errs++;
      $display("FAIL reset_outputs: got %b, want 00000",
               {bus.out_ready, bus.out_enable, bus.out_data, bus.out_busy, bus.out_error});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vecs++;
    if (bus.out_ready !== 1'b1 || bus.out_busy !== 1'b0) begin
      errs++;
      $display("FAIL reset_release: got ready %b busy %b, want 1 0", bus.out_ready, bus.out_busy);
    end
  endtask

  task automatic test_single();
    int w;
    fb = '{8'hA5};
    add_frame(1'b1);
    rec = 1'b1;
    send_byte(8'hA5, 1'b1, w);
    vecs++;
    if (bus.out_enable !== 1'b0) begin
      errs++;
      $display("FAIL single_latency_early: got enable %b, want 0", bus.out_enable);
    end
    @(negedge clk);
    vecs++;
    if (bus.out_enable !== 1'b1 || bus.out_data !== 1'b1 || bus.out_busy !== 1'b1) begin
      errs++;
      $display("FAIL single_sof: got en/d/busy %b%b%b, want 111", bus.out_enable, bus.out_data, bus.out_busy);
    end
    drain();
    rec = 1'b0;
    check_trace("single", -1, 0);
  endtask

  task automatic test_back_to_back();
    int w;
    fb = '{8'h26, 8'h00};
    add_frame(1'b1);
    rec = 1'b1;
    send_byte(8'h26, 1'b0, w);
    send_byte(8'h00, 1'b1, w);
    drain();
    rec = 1'b0;
    check_trace("back_to_back", -1, 0);
  endtask

  task automatic test_random_frames();
    int w, nb;
    logic [7:0] bytes[$];
    logic [7:0] b;
    for (int f = 0; f < 4; f++) begin
      nb = $urandom_range(1, 3);
      for (int k = 0; k < nb; k++) begin
        b = 8'($urandom);
        bytes.push_back(b);
        fb.push_back(b);
      end
      bytes.push_back({7'b0, 1'b1});
      add_frame(1'b1);
      bytes.push_back(8'(nb));
    end
    rec = 1'b1;
    // bytes[] holds per frame: data..., marker, count; replay it
    begin
      int i = 0;
      while (i < bytes.size()) begin
        int j = i;
        while (bytes[j + 1] !== 8'h01 || (j + 2 < bytes.size() && (j + 2 - i) !== bytes[j + 2] + 1)) j++;
        for (int k = i; k <= j; k++) send_byte(bytes[k], (k == j), w);
        i = j + 3;
      end
    end
    drain();
    rec = 1'b0;
    check_trace("random", GUARD * ETU, 0);
  endtask

  task automatic test_underrun();
    int w;
    fb = '{8'h12};
    add_frame(1'b0);
    rec = 1'b1;
    send_byte(8'h12, 1'b0, w);
    drain();
    rec = 1'b0;
    check_trace("underrun", -1, 1);
  endtask

  task automatic test_mid_reset();
    int w;
    send_byte(8'hFF, 1'b1, w);
    for (int n = 0; n < 200 && !bus.out_enable; n++) @(negedge clk);
    repeat (3 * ETU + 3) @(negedge clk);
    vecs++;
    if (bus.out_enable !== 1'b1) begin
      errs++;
      $display("FAIL mid_reset_precond: got enable %b, want 1", bus.out_enable);
    end
    #2 rst_n = 1'b0;
    #1;
    vecs++;
    if ({bus.out_enable, bus.out_data, bus.out_busy, bus.out_error, bus.out_ready} !== 5'b0) begin
      errs++;
      $display("FAIL mid_reset_async: got en/d/busy/err/rdy %b, want 00000",
               {bus.out_enable, bus.out_data, bus.out_busy, bus.out_error, bus.out_ready});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fb = '{8'h5A};
    add_frame(1'b1);
    rec = 1'b1;
    send_byte(8'h5A, 1'b1, w);
    drain();
    rec = 1'b0;
    check_trace("after_reset", -1, 0);
  endtask

  task automatic test_guard_accept();
    int w;
    fb = '{8'h3C};
    add_frame(1'b1);
    fb = '{8'h81};
    add_frame(1'b1);
    rec = 1'b1;
    send_byte(8'h3C, 1'b1, w);
    for (int n = 0; n < 200 && !bus.out_enable; n++) @(negedge clk);
    for (int n = 0; n < 400 && bus.out_enable; n++) @(negedge clk);
    send_byte(8'h81, 1'b1, w);
    vecs++;
    if (w !== 0) begin
      errs++;
      $display("FAIL guard_accept_wait: got %0d wait cycles, want 0", w);
    end
    drain();
    rec = 1'b0;
    check_trace("guard_accept", GUARD * ETU, 0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_byte  = 8'h00;
    bus.in_last  = 1'b0;
    test_reset();
    test_single();
    @(negedge clk);
    test_back_to_back();
    @(negedge clk);
    test_random_frames();
    @(negedge clk);
    test_underrun();
    @(negedge clk);
    test_mid_reset();
    @(negedge clk);
    test_guard_accept();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
